// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions used by the EX, MEM and WB stages.
//
// Contents:
//   OP_RTYPE, OP_ADDI, OP_LW, OP_SW : primary opcode field values (bits [31:26])
//   DMEM_AW                         : word-address width of the data memory
//   instr_class_e                   : coarse instruction class seen by MEM
//   classify()                      : opcode -> instr_class_e
//   addr_legal()                    : byte address legality for lw/sw
package mem_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Word address comes from EX_result[7:2]: 64 addressable words.
    localparam int DMEM_AW = 6;

    typedef enum logic [1:0] {
        CLS_ALU   = 2'd0,  // R-type / addi: pass ALU result through
        CLS_LOAD  = 2'd1,
        CLS_STORE = 2'd2,
        CLS_OTHER = 2'd3   // anything else: write-back value is 0
    } instr_class_e;

    function automatic instr_class_e classify(input logic [5:0] op);
        instr_class_e cls;
        case (op)
            OP_RTYPE, OP_ADDI: cls = CLS_ALU;
            OP_LW:             cls = CLS_LOAD;
            OP_SW:             cls = CLS_STORE;
            default:           cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

    // Legal data address: word aligned and inside the first 256 bytes.
    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr[31:8] == 24'h000000);
    endfunction

endpackage

// File: rtl/mem_stage_dmem.sv
// dmem: DEPTH x 32-bit data memory for the MEM stage.
//
// Ports:
//   clk      : write clock (posedge)
//   rst      : asynchronous active-low clear of every word
//   we_i     : write enable, sampled on posedge clk
//   waddr_i  : write word address
//   wdata_i  : write data
//   raddr_i  : read word address
//   rdata_o  : read data (combinational from the array; the caller registers it)
//
// Words at or above DEPTH (only possible when DEPTH < 2**DMEM_AW) read as 0
// and ignore writes.
module dmem
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [DMEM_AW-1:0] waddr_i,
    input  logic [31:0]        wdata_i,
    input  logic [DMEM_AW-1:0] raddr_i,
    output logic [31:0]        rdata_o
);

    logic [31:0] mem_q [DEPTH];

    logic waddr_in_range;
    logic raddr_in_range;

    assign waddr_in_range = (int'(waddr_i) < DEPTH);
    assign raddr_in_range = (int'(raddr_i) < DEPTH);

    // The clear must be asynchronous, so the whole array lives in flops
    // rather than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && waddr_in_range) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = raddr_in_range ? mem_q[raddr_i] : 32'h0;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Decodes the instruction leaving EX, checks
// lw/sw address legality, accesses the data memory and registers the
// write-back value for WB.
//
// Ports:
//   clk             : stage clock, all state updates on posedge
//   rst             : asynchronous active-low reset (outputs and memory cleared)
//   stall           : hold request; no state or memory change while high
//   EX_instruction  : instruction from EX, opcode in [31:26]
//   EX_result       : ALU result (effective address for lw/sw, value otherwise)
//   EX_storedata    : rt operand, sw data
//   MEM_instruction : registered copy of EX_instruction
//   Readdata        : registered write-back value
//   fault           : registered, high for an lw/sw with an illegal address
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] EX_instruction,
    input  logic [31:0] EX_result,
    input  logic [31:0] EX_storedata,
    output logic [31:0] MEM_instruction,
    output logic [31:0] Readdata,
    output logic        fault
);

    // ------------------------------------------------------------------
    // Decode and legality
    // ------------------------------------------------------------------
    instr_class_e        cls;
    logic                addr_ok;
    logic                is_mem_op;
    logic [DMEM_AW-1:0]  word_addr;

    assign cls       = classify(EX_instruction[31:26]);
    assign addr_ok   = addr_legal(EX_result);
    assign is_mem_op = (cls == CLS_LOAD) || (cls == CLS_STORE);
    assign word_addr = EX_result[7:2];

    // ------------------------------------------------------------------
    // Data memory. The store lands on the same posedge that registers the
    // sw, so an lw in the next cycle already sees the new word.
    // ------------------------------------------------------------------
    logic        dmem_we;
    logic [31:0] dmem_rdata;

    assign dmem_we = (cls == CLS_STORE) && addr_ok && !stall;

    dmem #(
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (dmem_we),
        .waddr_i (word_addr),
        .wdata_i (EX_storedata),
        .raddr_i (word_addr),
        .rdata_o (dmem_rdata)
    );

    // ------------------------------------------------------------------
    // Next-state for the output pipeline register
    // ------------------------------------------------------------------
    logic [31:0] mem_instr_d, mem_instr_q;
    logic [31:0] readdata_d,  readdata_q;
    logic        fault_d,     fault_q;

    always_comb begin
        mem_instr_d = EX_instruction;
        readdata_d  = 32'h0;
        fault_d     = is_mem_op && !addr_ok;
        case (cls)
            CLS_ALU:   readdata_d = EX_result;
            CLS_LOAD:  readdata_d = addr_ok ? dmem_rdata : 32'h0;
            CLS_STORE: readdata_d = 32'h0;
            default:   readdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_instr_q <= '0;
            readdata_q  <= '0;
            fault_q     <= 1'b0;
        end else if (!stall) begin
            mem_instr_q <= mem_instr_d;
            readdata_q  <= readdata_d;
            fault_q     <= fault_d;
        end
    end

    assign MEM_instruction = mem_instr_q;
    assign Readdata        = readdata_q;
    assign fault           = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage. A behavioural model (byte-addressed
// associative memory plus the opcode rules) predicts the registered outputs
// after every posedge; directed tasks cover the named scenarios and a random
// phase mixes opcodes, legal/illegal addresses and stalls.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] EX_instruction;
    logic [31:0] EX_result;
    logic [31:0] EX_storedata;
    logic [31:0] MEM_instruction;
    logic [31:0] Readdata;
    logic        fault;

    int vectors;
    int miscompares;

    // Reference model state
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] exp_instr;
    logic [31:0] exp_rd;
    logic        exp_fault;

    mem_stage #(
        .DEPTH (64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .EX_instruction  (EX_instruction),
        .EX_result       (EX_result),
        .EX_storedata    (EX_storedata),
        .MEM_instruction (MEM_instruction),
        .Readdata        (Readdata),
        .fault           (fault)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Model and driver
    // ------------------------------------------------------------------
    function automatic logic [31:0] mk(input logic [5:0] op);
        logic [25:0] low;
        low = 26'($urandom);
        return {op, low};
    endfunction

    task automatic model_reset();
        ref_mem.delete();
        exp_instr = 32'h0;
        exp_rd    = 32'h0;
        exp_fault = 1'b0;
    endtask

    task automatic model_step(input logic [31:0] ins, input logic [31:0] res,
                              input logic [31:0] sd, input logic stl);
        int unsigned op;
        int unsigned a;
        bit          legal;
        if (stl) return;
        op    = int'(ins[31:26]);
        a     = res;
        legal = (a % 4 == 0) && (a < 256);
        exp_instr = ins;
        exp_rd    = 32'h0;
        exp_fault = 1'b0;
        if (op == 35) begin
            exp_fault = !legal;
            if (legal && ref_mem.exists(a)) exp_rd = ref_mem[a];
        end else if (op == 43) begin
            exp_fault = !legal;
            if (legal) ref_mem[a] = sd;
        end else if (op == 0 || op == 8) begin
            exp_rd = res;
        end
    endtask

    // Drives inputs now (always called away from a posedge), clocks once,
    // then advances the model.
    task automatic step(input logic [31:0] ins, input logic [31:0] res,
                        input logic [31:0] sd, input logic stl);
        EX_instruction = ins;
        EX_result      = res;
        EX_storedata   = sd;
        stall          = stl;
        @(posedge clk);
        #1;
        model_step(ins, res, sd, stl);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        stall = 1'b0;
        EX_instruction = 32'h0;
        EX_result = 32'h0;
        EX_storedata = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (MEM_instruction !== 32'h0 || Readdata !== 32'h0 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got instr=%h rd=%h fault=%b, want all zero",
                     MEM_instruction, Readdata, fault);
        end
        #3 rst = 1'b1;
    endtask

    task automatic test_sw_lw();
        logic [31:0] ins [2];
        ins[0] = mk(6'b101011);
        ins[1] = mk(6'b100011);
        step(ins[0], 32'h10, 32'hDEADBEEF, 1'b0);
        vectors++;
        if ({MEM_instruction, Readdata, fault} !== {exp_instr, exp_rd, exp_fault}) begin
            miscompares++;
            $display("FAIL sw_lw sw: got %h/%h/%b want %h/%h/%b", MEM_instruction, Readdata,
                     fault, exp_instr, exp_rd, exp_fault);
        end
        step(ins[1], 32'h10, $urandom, 1'b0);
        vectors++;
        if (Readdata !== 32'hDEADBEEF || fault !== 1'b0 || MEM_instruction !== ins[1]) begin
            miscompares++;
            $display("FAIL sw_lw lw: got rd=%h fault=%b instr=%h want rd=deadbeef fault=0 instr=%h",
                     Readdata, fault, MEM_instruction, ins[1]);
        end
    endtask

    task automatic test_addi();
        logic [31:0] w;
        w = mk(6'b001000);
        step(w, 32'hFFFFFFF6, $urandom, 1'b0);
        vectors++;
        if (Readdata !== 32'hFFFFFFF6 || MEM_instruction !== w || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL addi: got rd=%h instr=%h fault=%b want rd=fffffff6 instr=%h fault=0",
                     Readdata, MEM_instruction, fault, w);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] addr [3];
        logic [31:0] ins  [3];
        logic        want_fault [3];
        addr[0] = 32'h12;  ins[0] = mk(6'b100011); want_fault[0] = 1'b1;
        addr[1] = 32'h100; ins[1] = mk(6'b100011); want_fault[1] = 1'b1;
        addr[2] = $urandom; ins[2] = mk(6'b000000); want_fault[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(ins[i], addr[i], $urandom, 1'b0);
            vectors++;
            if ({MEM_instruction, Readdata, fault} !== {exp_instr, exp_rd, exp_fault}
                || fault !== want_fault[i]) begin
                miscompares++;
                $display("FAIL illegal[%0d]: got %h/%h/%b want %h/%h/%b", i, MEM_instruction,
                         Readdata, fault, exp_instr, exp_rd, want_fault[i]);
            end
        end
    endtask

    task automatic test_sw_illegal();
        step(mk(6'b101011), 32'h102, 32'h5, 1'b0);
        vectors++;
        if (fault !== 1'b1 || Readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL sw_illegal: got fault=%b rd=%h want fault=1 rd=0", fault, Readdata);
        end
        step(mk(6'b100011), 32'h0, $urandom, 1'b0);
        vectors++;
        if (Readdata !== 32'h0 || fault !== 1'b0 || Readdata !== exp_rd) begin
            miscompares++;
            $display("FAIL sw_illegal lw0: got rd=%h fault=%b want rd=0 fault=0", Readdata, fault);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_instr;
        logic [31:0] held_rd;
        logic        held_fault;
        step(mk(6'b001000), $urandom, $urandom, 1'b0);
        held_instr = exp_instr;
        held_rd    = exp_rd;
        held_fault = exp_fault;
        for (int i = 0; i < 3; i++) begin
            step(mk(6'b101011), 32'h8, $urandom | 32'h1, 1'b1);
            vectors++;
            if ({MEM_instruction, Readdata, fault} !== {held_instr, held_rd, held_fault}) begin
                miscompares++;
                $display("FAIL stall[%0d]: got %h/%h/%b want %h/%h/%b", i, MEM_instruction,
                         Readdata, fault, held_instr, held_rd, held_fault);
            end
        end
        step(mk(6'b100011), 32'h8, $urandom, 1'b0);
        vectors++;
        if (Readdata !== 32'h0 || fault !== 1'b0 || MEM_instruction !== exp_instr) begin
            miscompares++;
            $display("FAIL stall lw8: got rd=%h fault=%b instr=%h want rd=0 fault=0 instr=%h",
                     Readdata, fault, MEM_instruction, exp_instr);
        end
    endtask

    task automatic test_reset_mid();
        step(mk(6'b101011), 32'h20, 32'h1234, 1'b0);
        step(mk(6'b100011), 32'h20, $urandom, 1'b0);
        vectors++;
        if (Readdata !== 32'h1234) begin
            miscompares++;
            $display("FAIL reset_mid store: got rd=%h want rd=00001234", Readdata);
        end
        #3 rst = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (MEM_instruction !== 32'h0 || Readdata !== 32'h0 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid async: got %h/%h/%b want all zero",
                     MEM_instruction, Readdata, fault);
        end
        // A store presented while rst is low must not commit.
        EX_instruction = mk(6'b101011);
        EX_result      = 32'h24;
        EX_storedata   = 32'h5555;
        @(posedge clk);
        #1;
        vectors++;
        if (MEM_instruction !== 32'h0 || Readdata !== 32'h0 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid held: got %h/%h/%b want all zero",
                     MEM_instruction, Readdata, fault);
        end
        #3 rst = 1'b1;
        step(mk(6'b100011), 32'h20, $urandom, 1'b0);
        vectors++;
        if (Readdata !== 32'h0 || fault !== 1'b0 || MEM_instruction !== exp_instr) begin
            miscompares++;
            $display("FAIL reset_mid lw20: got rd=%h fault=%b want rd=0 fault=0", Readdata, fault);
        end
        step(mk(6'b100011), 32'h24, $urandom, 1'b0);
        vectors++;
        if (Readdata !== 32'h0 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid lw24: got rd=%h fault=%b want rd=0 fault=0", Readdata, fault);
        end
    endtask

    task automatic test_random();
        logic [5:0]  op;
        logic [31:0] addr;
        logic        stl;
        int          sel;
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: op = 6'b100011;
                3, 4, 5: op = 6'b101011;
                6:       op = 6'b000000;
                7:       op = 6'b001000;
                default: op = 6'($urandom);
            endcase
            sel = $urandom_range(0, 7);
            if (sel < 5)       addr = 32'($urandom_range(0, 63)) * 4;
            else if (sel == 5) addr = 32'($urandom_range(0, 255)) | 32'h1;
            else if (sel == 6) addr = 32'($urandom_range(256, 4096));
            else               addr = $urandom;
            stl = ($urandom_range(0, 4) == 0);
            step(mk(op), addr, $urandom, stl);
            vectors++;
            if ({MEM_instruction, Readdata, fault} !== {exp_instr, exp_rd, exp_fault}) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h/%h/%b want %h/%h/%b (addr=%h stall=%b)", n,
                         MEM_instruction, Readdata, fault, exp_instr, exp_rd, exp_fault, addr, stl);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_sw_lw();
        test_addi();
        test_illegal();
        test_sw_illegal();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL: clk  input  1  stage clock; all state updates on posedge.
REQ-002 SHALL: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: stall  input  1  hold request; when high, no state changes and no store.
REQ-004 SHALL: EX_instruction  input  32  instruction leaving EX; opcode is [31:26].
REQ-005 SHALL: EX_result  input  32  ALU result: the effective address for lw/sw, the write value for R-type/addi.
REQ-006 SHALL: EX_storedata  input  32  rt operand value, used as the sw data.
REQ-007 SHALL: MEM_instruction  output  32  registered copy of EX_instruction, consumed by WB.
REQ-008 SHALL: Readdata  output  32  registered write-back value, consumed by WB.
REQ-009 SHALL: fault  output  1  registered; high for the one instruction whose lw/sw address is illegal.
REQ-010 SHALL: DEPTH  parameter, default 64  data memory depth in 32-bit words.

Function
REQ-011 SHALL: on each posedge clk with stall=0, MEM_instruction be loaded with EX_instruction, so latency is exactly 1 cycle.
REQ-012 SHALL: opcode 100011 (lw) load Readdata with mem[EX_result[7:2]] when the address is legal, else with 0.
REQ-013 SHALL: opcode 101011 (sw) write EX_storedata to mem[EX_result[7:2]] at the same posedge when the address is legal, and load Readdata with 0.
REQ-014 SHALL: opcodes 000000 (R-type) and 001000 (addi) load Readdata with EX_result unchanged.
REQ-015 SHALL: any other opcode, including 0x00000000 treated as R-type, follow REQ-014 or load Readdata with 0 as decoded; no memory write occurs.
REQ-016 SHALL: a legal address be one with EX_result[1:0]=00 and EX_result[31:8]=0.
REQ-017 SHALL: an illegal lw/sw set fault=1 for that cycle, suppress the store, and return 0 for a load.
REQ-018 SHALL: fault=0 for every non-memory opcode.
REQ-019 SHALL: a lw in the cycle directly after a sw to the same address return the newly stored value, because the memory is written at the sw posedge.
REQ-020 SHALL: stall=1 hold MEM_instruction, Readdata, fault and all memory contents unchanged.
REQ-021 SHALL: reads be synchronous with no combinational path from EX_* to the outputs.

Reset
REQ-022 SHALL: rst=0 asynchronously force MEM_instruction=0, Readdata=0 and fault=0.
REQ-023 SHALL: rst=0 asynchronously clear all DEPTH memory words to 0.
REQ-024 SHALL: a sw whose posedge coincides with rst low not be committed.
REQ-025 SHALL: the first posedge after rst rises behave per REQ-011..REQ-021 with no extra dead cycle.

Structure
REQ-026 SHALL: opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW) live in a shared pipeline definitions package, which the WB and EX stages also use.
REQ-027 SHALL: the data memory be one sub-module, dmem (DEPTH x 32, one synchronous write port, one read port, async clear), instantiated once inside mem_stage.
REQ-028 SHALL: decode, legality check and the output pipeline register reside in mem_stage itself.

Verification
REQ-029 SHALL: sw with EX_result=0x10 and EX_storedata=0xDEADBEEF, then lw with EX_result=0x10 -> after the lw cycle Readdata=0xDEADBEEF and fault=0.
REQ-030 SHALL: addi with EX_result=0xFFFFFFF6 -> after 1 cycle Readdata=0xFFFFFFF6 and MEM_instruction equals the addi word.
REQ-031 SHALL: lw with EX_result=0x12 (misaligned) and lw with EX_result=0x100 (out of range) -> Readdata=0 and fault=1 each cycle; a following R-type gives fault=0.
REQ-032 SHALL: sw with EX_result=0x102 and data 0x5 -> fault=1, and a subsequent lw of 0x00 still returns 0.
REQ-033 SHALL: stall=1 for 3 cycles while presenting a sw with EX_result=0x8 -> outputs frozen, and a subsequent lw of 0x8 returns 0.
REQ-034 SHALL: rst pulsed low mid-cycle after storing 0x1234 at 0x20 -> outputs are 0 immediately, and a subsequent lw of 0x20 returns 0.
